execute_stage: RTL and testbench

- Execute slice of the 5-stage RV32I pipeline: DEC/EX pipeline register, operand forwarding muxes, ALU, and EX/MEM pipeline register.
- Sits between decoder/controlUnit/register file and the data RAM / MEM_WB register.
- Hazard unit and forwarding unit stay external; this block exports the registered fields they need and consumes their decisions.

---
 rtl/execute_stage_pkg.sv | 46 ++++
 rtl/execute_alu.sv | 32 +++
 rtl/execute_stage.sv | 105 ++++++++++
 tb/tb_execute_stage.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/execute_stage_pkg.sv
// Shared widths, ALU function codes, forwarding selects and the DEC/EX record
// for the RV32I execute slice.
package execute_stage_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned RA_W    = 5;
  localparam int unsigned ALUOP_W = 5;
  localparam int unsigned DCC_W   = 3;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_PASSB = 4'd10
  } aluFunc_t;

  // Encoding 2'b11 is deliberately absent and falls back to FWD_REG.
  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwdSel_t;

  localparam logic [DCC_W-1:0] DCC_NONE = '0;

  typedef struct packed {
    logic [6:0]         opcode;
    logic [RA_W-1:0]    rd;
    logic [RA_W-1:0]    rs1;
    logic [RA_W-1:0]    rs2;
    logic [XLEN-1:0]    rs1Data;
    logic [XLEN-1:0]    rs2Data;
    logic [ALUOP_W-1:0] aluop;
    logic [XLEN-1:0]    imm;
    logic [DCC_W-1:0]   dcc;
    logic               we;
  } decEx_t;

endpackage

// File: rtl/execute_alu.sv
// Combinational RV32I ALU; unknown function codes produce zero.
module execute_alu
  import execute_stage_pkg::*;
(
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = a - b;
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_XOR:   result = a ^ b;
      ALU_SLL:   result = a << shamt;
      ALU_SRL:   result = a >> shamt;
      ALU_SRA:   result = $signed(a) >>> shamt;
      ALU_SLT:   result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU:  result = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_PASSB: result = b;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// Execute slice: DEC/EX register, operand forwarding, ALU and EX/MEM register.
module execute_stage
  import execute_stage_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_bubble,
  input  logic [6:0]         dec_opcode,
  input  logic [RA_W-1:0]    dec_rd,
  input  logic [RA_W-1:0]    dec_rs1,
  input  logic [RA_W-1:0]    dec_rs2,
  input  logic [XLEN-1:0]    dec_rs1_data,
  input  logic [XLEN-1:0]    dec_rs2_data,
  input  logic [ALUOP_W-1:0] dec_aluop,
  input  logic [XLEN-1:0]    dec_imm,
  input  logic [DCC_W-1:0]   dec_dcc,
  input  logic               dec_we,
  input  logic [1:0]         fwd_sel1,
  input  logic [1:0]         fwd_sel2,
  input  logic [XLEN-1:0]    wb_data,
  output logic [RA_W-1:0]    ex_rd,
  output logic [6:0]         ex_opcode,
  output logic [RA_W-1:0]    ex_rs1,
  output logic [RA_W-1:0]    ex_rs2,
  output logic [XLEN-1:0]    alu_result,
  output logic [XLEN-1:0]    mem_alu_data,
  output logic [XLEN-1:0]    mem_rs2_data,
  output logic [DCC_W-1:0]   mem_dcc,
  output logic               mem_we,
  output logic [RA_W-1:0]    mem_rd
);

  decEx_t decIn;
  decEx_t ex;
  logic [XLEN-1:0] opA;
  logic [XLEN-1:0] rs2Fwd;
  logic [XLEN-1:0] opB;

  assign decIn = '{opcode:  dec_opcode,
                   rd:      dec_rd,
                   rs1:     dec_rs1,
                   rs2:     dec_rs2,
                   rs1Data: dec_rs1_data,
                   rs2Data: dec_rs2_data,
                   aluop:   dec_aluop,
                   imm:     dec_imm,
                   dcc:     dec_dcc,
                   we:      dec_we};

  // A bubble is simply an all-zero record: opcode 0 / dcc 0 / we 0 is a NOP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             ex <= '0;
    else if (stall_bubble) ex <= '0;
    else                   ex <= decIn;
  end

  always_comb begin
    opA = ex.rs1Data;
    case (fwd_sel1)
      FWD_MEM: opA = mem_alu_data;
      FWD_WB:  opA = wb_data;
      default: opA = ex.rs1Data;
    endcase
  end

  always_comb begin
    rs2Fwd = ex.rs2Data;
    case (fwd_sel2)
      FWD_MEM: rs2Fwd = mem_alu_data;
      FWD_WB:  rs2Fwd = wb_data;
      default: rs2Fwd = ex.rs2Data;
    endcase
  end

  assign opB = ex.aluop[4] ? ex.imm : rs2Fwd;

  execute_alu u_alu (
    .op     (ex.aluop[3:0]),
    .a      (opA),
    .b      (opB),
    .result (alu_result)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_alu_data <= '0;
      mem_rs2_data <= '0;
      mem_dcc      <= DCC_NONE;
      mem_we       <= 1'b0;
      mem_rd       <= '0;
    end else begin
      mem_alu_data <= alu_result;
      mem_rs2_data <= rs2Fwd;
      mem_dcc      <= ex.dcc;
      mem_we       <= ex.we;
      mem_rd       <= ex.rd;
    end
  end

  assign ex_rd     = ex.rd;
  assign ex_opcode = ex.opcode;
  assign ex_rs1    = ex.rs1;
  assign ex_rs2    = ex.rs2;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: ALU vector table, hand-written
// pipeline sequences, and randomized traffic against a reference model.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_bubble;
  logic [6:0]  dec_opcode;
  logic [4:0]  dec_rd, dec_rs1, dec_rs2;
  logic [31:0] dec_rs1_data, dec_rs2_data;
  logic [4:0]  dec_aluop;
  logic [31:0] dec_imm;
  logic [2:0]  dec_dcc;
  logic        dec_we;
  logic [1:0]  fwd_sel1, fwd_sel2;
  logic [31:0] wb_data;
  logic [4:0]  ex_rd, ex_rs1, ex_rs2, mem_rd;
  logic [6:0]  ex_opcode;
  logic [31:0] alu_result, mem_alu_data, mem_rs2_data;
  logic [2:0]  mem_dcc;
  logic        mem_we;

  int total = 0;
  int bad   = 0;

  execute_stage dut (
    .clk(clk), .reset(reset), .stall_bubble(stall_bubble),
    .dec_opcode(dec_opcode), .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rs1_data(dec_rs1_data), .dec_rs2_data(dec_rs2_data),
    .dec_aluop(dec_aluop), .dec_imm(dec_imm), .dec_dcc(dec_dcc), .dec_we(dec_we),
    .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .wb_data(wb_data),
    .ex_rd(ex_rd), .ex_opcode(ex_opcode), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .alu_result(alu_result), .mem_alu_data(mem_alu_data), .mem_rs2_data(mem_rs2_data),
    .mem_dcc(mem_dcc), .mem_we(mem_we), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // Reference model: what instruction sits in EX, and what sits in MEM.
  typedef struct {
    int unsigned opcode, rd, rs1, rs2, aluop, dcc, we;
    logic [31:0] d1, d2, imm;
  } exModel_t;
  typedef struct {
    logic [31:0] alu, st;
    int unsigned dcc, we, rd;
  } memModel_t;

  exModel_t  mEx;
  memModel_t mMem;

  function automatic logic [31:0] refAlu(int unsigned f, logic [31:0] a, logic [31:0] b);
    int unsigned sh;
    longint sa, sb;
    sh = b % 32;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f)
      0:  return a + b;
      1:  return a - b;
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return a * (33'd1 << sh);
      6:  return a / (33'd1 << sh);
      7:  return 32'(sa >>> sh);
      8:  return (sa < sb) ? 32'd1 : 32'd0;
      9:  return ({1'b0, a} < {1'b0, b}) ? 32'd1 : 32'd0;
      10: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] pick(logic [1:0] sel, logic [31:0] regVal);
    if (sel == 2'd1) return mMem.alu;
    if (sel == 2'd2) return wb_data;
    return regVal;
  endfunction

  function automatic logic [31:0] expAlu();
    logic [31:0] b;
    b = (mEx.aluop >= 16) ? mEx.imm : pick(fwd_sel2, mEx.d2);
    return refAlu(mEx.aluop % 16, pick(fwd_sel1, mEx.d1), b);
  endfunction

  task automatic modelClear();
    mEx  = '{default: 0};
    mMem = '{default: 0};
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic checkAll();
    chk("ex_rd", 32'(ex_rd), mEx.rd);
    chk("ex_opcode", 32'(ex_opcode), mEx.opcode);
    chk("ex_rs1", 32'(ex_rs1), mEx.rs1);
    chk("ex_rs2", 32'(ex_rs2), mEx.rs2);
    chk("alu_result", alu_result, expAlu());
    chk("mem_alu_data", mem_alu_data, mMem.alu);
    chk("mem_rs2_data", mem_rs2_data, mMem.st);
    chk("mem_dcc", 32'(mem_dcc), mMem.dcc);
    chk("mem_we", 32'(mem_we), mMem.we);
    chk("mem_rd", 32'(mem_rd), mMem.rd);
  endtask

  // One rising edge; the model advances with the inputs seen at that edge.
  task automatic tick();
    memModel_t nMem;
    @(posedge clk);
    nMem.alu = expAlu();
    nMem.st  = pick(fwd_sel2, mEx.d2);
    nMem.dcc = mEx.dcc;
    nMem.we  = mEx.we;
    nMem.rd  = mEx.rd;
    mMem = nMem;
    if (stall_bubble) mEx = '{default: 0};
    else begin
      mEx.opcode = dec_opcode; mEx.rd = dec_rd; mEx.rs1 = dec_rs1; mEx.rs2 = dec_rs2;
      mEx.aluop = dec_aluop; mEx.dcc = dec_dcc; mEx.we = dec_we;
      mEx.d1 = dec_rs1_data; mEx.d2 = dec_rs2_data; mEx.imm = dec_imm;
    end
    #1;
  endtask

  task automatic setDec(logic [6:0] op, logic [4:0] rd, logic [31:0] d1, logic [31:0] d2,
                        logic [31:0] imm, logic [4:0] aluop, logic [2:0] dcc, logic we);
    dec_opcode = op; dec_rd = rd; dec_rs1 = 5'd1; dec_rs2 = 5'd2;
    dec_rs1_data = d1; dec_rs2_data = d2; dec_imm = imm;
    dec_aluop = aluop; dec_dcc = dcc; dec_we = we;
  endtask

  typedef struct {
    string       name;
    logic [31:0] a, b, imm;
    logic [4:0]  aluop;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{"addi",  32'd5,         32'd0,  32'd7,         5'h10, 32'd12};
    vecs[1]  = '{"sub",   32'h10,        32'h20, 32'd0,         5'h01, 32'hFFFF_FFF0};
    vecs[2]  = '{"srai",  32'h8000_0000, 32'd0,  32'd4,         5'h17, 32'hF800_0000};
    vecs[3]  = '{"srli",  32'h8000_0000, 32'd0,  32'd4,         5'h16, 32'h0800_0000};
    vecs[4]  = '{"slt",   32'hFFFF_FFFF, 32'd1,  32'd0,         5'h08, 32'd1};
    vecs[5]  = '{"sltu",  32'hFFFF_FFFF, 32'd1,  32'd0,         5'h09, 32'd0};
    vecs[6]  = '{"slli",  32'd1,         32'd0,  32'd31,        5'h15, 32'h8000_0000};
    vecs[7]  = '{"sll5b", 32'd1,         32'h21, 32'd0,         5'h05, 32'd2};
    vecs[8]  = '{"and",   32'hF0F0_FF00, 32'h0FF0_F0F0, 32'd0,  5'h02, 32'h00F0_F000};
    vecs[9]  = '{"or",    32'hF000_0001, 32'h0000_0F10, 32'd0,  5'h03, 32'hF000_0F11};
    vecs[10] = '{"xori",  32'hFFFF_0000, 32'd0,  32'h0F0F_0F0F, 5'h14, 32'hF0F0_0F0F};
    vecs[11] = '{"lui",   32'h1234_5678, 32'd0,  32'hABCD_E000, 5'h1A, 32'hABCD_E000};
    vecs[12] = '{"undef", 32'h1234_5678, 32'd9,  32'd0,         5'h0B, 32'd0};

    reset = 1'b1; stall_bubble = 1'b0;
    setDec(7'd0, 5'd0, '0, '0, '0, 5'd0, 3'd0, 1'b0);
    fwd_sel1 = 2'd0; fwd_sel2 = 2'd0; wb_data = '0;
    modelClear();
    #12;
    checkAll();
    reset = 1'b0;

    // ALU vector table: operands through DEC/EX, then result into EX/MEM.
    foreach (vecs[i]) begin
      setDec(7'h33, 5'd4, vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].aluop, 3'd0, 1'b1);
      tick();
      chk({vecs[i].name, "_alu"}, alu_result, vecs[i].exp);
      tick();
      chk({vecs[i].name, "_mem"}, mem_alu_data, vecs[i].exp);
    end

    // ADDI x3 = 5 + 7 through both stages.
    setDec(7'h13, 5'd3, 32'd5, 32'd0, 32'd7, 5'h10, 3'd0, 1'b1);
    tick();
    chk("addi_ex_rd", 32'(ex_rd), 32'd3);
    chk("addi_ex_alu", alu_result, 32'd12);
    setDec(7'd0, 5'd0, '0, '0, '0, 5'd0, 3'd0, 1'b0);
    tick();
    chk("addi_mem_alu", mem_alu_data, 32'd12);
    chk("addi_mem_rd", 32'(mem_rd), 32'd3);
    chk("addi_mem_we", 32'(mem_we), 32'd1);

    // Forwarding: producer leaves 0x10 in EX/MEM; consumer forwards it and wb_data.
    setDec(7'h13, 5'd6, 32'd0, 32'd0, 32'h10, 5'h10, 3'd0, 1'b1);
    tick();
    setDec(7'h23, 5'd0, 32'd1, 32'h99, 32'd0, 5'h01, 3'b010, 1'b0);
    tick();
    fwd_sel1 = 2'd1; fwd_sel2 = 2'd2; wb_data = 32'h20;
    #1;
    chk("fwd_mem_src", mem_alu_data, 32'h10);
    chk("fwd_sub", alu_result, 32'hFFFF_FFF0);
    setDec(7'd0, 5'd0, '0, '0, '0, 5'd0, 3'd0, 1'b0);
    tick();
    chk("store_data_fwd", mem_rs2_data, 32'h20);
    chk("store_dcc", 32'(mem_dcc), 32'b010);
    fwd_sel1 = 2'd3; fwd_sel2 = 2'd3; wb_data = 32'h5555;
    #1;
    checkAll();

    // sel 11 behaves as register data for both operands.
    setDec(7'h33, 5'd7, 32'd100, 32'd30, 32'd0, 5'h01, 3'd0, 1'b1);
    tick();
    chk("sel11_sub", alu_result, 32'd70);
    fwd_sel1 = 2'd0; fwd_sel2 = 2'd0;

    // Bubble: a valid store is replaced by a NOP.
    setDec(7'h23, 5'd5, 32'd1, 32'd2, 32'd3, 5'h10, 3'b010, 1'b1);
    stall_bubble = 1'b1;
    tick();
    chk("bubble_ex_opcode", 32'(ex_opcode), 32'd0);
    chk("bubble_ex_rd", 32'(ex_rd), 32'd0);
    stall_bubble = 1'b0;
    setDec(7'd0, 5'd0, '0, '0, '0, 5'd0, 3'd0, 1'b0);
    tick();
    chk("bubble_mem_we", 32'(mem_we), 32'd0);
    chk("bubble_mem_dcc", 32'(mem_dcc), 32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      stall_bubble = ($urandom_range(0, 3) == 0);
      setDec(7'($urandom), 5'($urandom), $urandom, $urandom,
             ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom,
             5'($urandom_range(0, 31)), 3'($urandom), 1'($urandom));
      dec_rs1 = 5'($urandom); dec_rs2 = 5'($urandom);
      fwd_sel1 = 2'($urandom); fwd_sel2 = 2'($urandom); wb_data = $urandom;
      #1;
      checkAll();
      tick();
    end

    // Asynchronous reset in mid-cycle with live inputs.
    setDec(7'h13, 5'd9, 32'd1, 32'd2, 32'd3, 5'h10, 3'b001, 1'b1);
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    modelClear();
    chk("rst_ex_opcode", 32'(ex_opcode), 32'd0);
    chk("rst_ex_rd", 32'(ex_rd), 32'd0);
    chk("rst_mem_alu", mem_alu_data, 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_mem_dcc", 32'(mem_dcc), 32'd0);
    @(posedge clk);
    #1;
    checkAll();
    reset = 1'b0;
    tick();
    checkAll();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
